// File: rtl/pipeline_skid_register_if.sv
// Handshake bundle for pipeline_skid_register: upstream/downstream valid-ready
// plus flush and the occupancy status.
interface pipeline_skid_register_if #(
  parameter int unsigned WIDTH = 32
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       occupancy;

  // Producer/consumer side that drives the block.
  modport master (
    output flush, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, occupancy
  );

  // The skid register itself.
  modport slave (
    input  flush, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, occupancy
  );
endinterface

// File: rtl/pipeline_skid_register.sv
// Two-entry skid register: main holds the presented entry, skid catches the
// entry accepted in the cycle downstream stalls. in_ready is registered so it
// has no combinational path from out_ready.
module pipeline_skid_register #(
  parameter int unsigned      WIDTH        = 32,
  parameter logic [WIDTH-1:0] BUBBLE_VALUE = '0
) (
  input logic                     clock,
  input logic                     reset,
  pipeline_skid_register_if.slave bus
);

  // Encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StFull  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             in_ready_q;
  logic [WIDTH-1:0] main_q, skid_q;
  logic             main_load, main_from_skid, skid_load;
  logic             out_valid;
  logic             accept, drain;

  assign accept = bus.in_valid & in_ready_q;
  assign drain  = out_valid & bus.out_ready;

  // State register; in_ready is precomputed from the next state.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= StEmpty;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != StFull);
    end
  end

  // Next-state and payload load decode; reset and flush suppress all loads.
  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    unique case (state_q)
      StEmpty: begin
        if (accept) begin
          main_load = 1'b1;
          state_d   = StOne;
        end
      end
      StOne: begin
        if (accept && drain) begin
          main_load = 1'b1;
        end else if (accept) begin
          skid_load = 1'b1;
          state_d   = StFull;
        end else if (drain) begin
          state_d = StEmpty;
        end
      end
      StFull: begin
        if (drain) begin
          main_load      = 1'b1;
          main_from_skid = 1'b1;
          state_d        = StOne;
        end
      end
      default: state_d = StEmpty;
    endcase
    if (!reset || bus.flush) begin
      state_d   = StEmpty;
      main_load = 1'b0;
      skid_load = 1'b0;
    end
  end

  // Payload registers only move when loading, keeping them quiet under stall.
  always_ff @(posedge clock) begin
    if (main_load) begin
      main_q <= main_from_skid ? skid_q : bus.in_data;
    end
    if (skid_load) begin
      skid_q <= bus.in_data;
    end
  end

  // Outputs: register contents are masked by the bubble when nothing is held.
  always_comb begin
    out_valid     = (state_q == StOne) || (state_q == StFull);
    bus.out_valid = out_valid;
    bus.out_data  = out_valid ? main_q : BUBBLE_VALUE;
    bus.occupancy = state_q;
    bus.in_ready  = in_ready_q;
  end

endmodule

// File: tb/tb_pipeline_skid_register.sv
module tb_pipeline_skid_register;
  localparam int unsigned      W  = 8;
  localparam logic [W-1:0]     BV = 8'h13;

  logic clock;
  logic reset;
  int   tests;
  int   fails;
  bit   chk_en;

  pipeline_skid_register_if #(.WIDTH(W)) bus ();

  pipeline_skid_register #(
    .WIDTH        (W),
    .BUBBLE_VALUE (BV)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference: queue of accepted payloads, oldest first.
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update on the same edge the DUT samples.
  always @(posedge clock) begin
    bit acc, drn;
    if (!reset || bus.flush) begin
      exp_q.delete();
    end else begin
      acc = bus.in_valid && (exp_q.size() < 2);
      drn = bus.out_ready && (exp_q.size() > 0);
      if (drn) void'(exp_q.pop_front());
      if (acc) exp_q.push_back(bus.in_data);
    end
  end

  // Monitor: compares presented output against the queue head each cycle.
  always @(negedge clock) begin
    if (chk_en) begin
      check("in_ready", 32'(bus.in_ready), 32'(exp_q.size() < 2));
      check("occupancy", 32'(bus.occupancy), 32'(exp_q.size()));
      check("out_valid", 32'(bus.out_valid), 32'(exp_q.size() > 0));
      if (bus.out_valid) begin
        if (exp_q.size() == 0) check("unexpected_output", 32'(bus.out_data), 32'hFFFF_FFFF);
        else check("out_data_order", 32'(bus.out_data), 32'(exp_q[0]));
      end else begin
        check("bubble_value", 32'(bus.out_data), 32'(BV));
      end
    end
  end

  // Drive inputs 1 after the edge; optionally probe in_ready against out_ready.
  task automatic step(input logic rst, input logic v, input logic [W-1:0] d,
                      input logic ordy, input logic fl, input bit probe = 1'b0);
    logic r0;
    @(posedge clock);
    #1;
    reset         = rst;
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = ordy;
    bus.flush     = fl;
    if (probe) begin
      #1 r0 = bus.in_ready;
      bus.out_ready = ~ordy;
      #1 check("in_ready_comb_path", 32'(bus.in_ready), 32'(r0));
      bus.out_ready = ordy;
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    chk_en = 1'b0;
    reset = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.out_ready = 1'b0;
    bus.flush = 1'b0;
    repeat (3) @(posedge clock);
    #1 chk_en = 1'b1;
    check("reset_occ", 32'(bus.occupancy), 32'd0);
    check("reset_in_ready", 32'(bus.in_ready), 32'd1);
    check("reset_bubble", 32'(bus.out_data), 32'(BV));

    // Streaming: first edge out of reset accepts.
    step(1, 1, 8'h01, 1, 0);
    step(1, 1, 8'h02, 1, 0);
    check("stream_d1", 32'(bus.out_data), 32'h01);
    check("stream_occ1", 32'(bus.occupancy), 32'd1);
    step(1, 1, 8'h03, 1, 0);
    check("stream_d2", 32'(bus.out_data), 32'h02);
    step(1, 0, 8'h00, 1, 0);
    check("stream_d3", 32'(bus.out_data), 32'h03);
    check("stream_occ3", 32'(bus.occupancy), 32'd1);
    step(1, 0, 8'h00, 1, 0);
    check("stream_idle", 32'(bus.out_data), 32'(BV));

    // Stall / skid.
    step(1, 1, 8'h0A, 0, 0);
    step(1, 1, 8'h0B, 0, 0);
    check("stall_a", 32'(bus.out_data), 32'h0A);
    step(1, 1, 8'h0C, 0, 0);
    check("stall_occ2", 32'(bus.occupancy), 32'd2);
    check("stall_not_ready", 32'(bus.in_ready), 32'd0);
    step(1, 1, 8'h0C, 0, 0);
    check("stall_hold_occ", 32'(bus.occupancy), 32'd2);
    step(1, 1, 8'h0C, 1, 0);
    check("stall_hold_a", 32'(bus.out_data), 32'h0A);
    step(1, 1, 8'h0C, 1, 0);
    check("skid_b", 32'(bus.out_data), 32'h0B);
    check("skid_ready", 32'(bus.in_ready), 32'd1);
    step(1, 0, 8'h00, 1, 0);
    check("skid_c", 32'(bus.out_data), 32'h0C);
    step(1, 0, 8'h00, 1, 0);
    check("skid_empty", 32'(bus.out_valid), 32'd0);

    // Flush from FULL with a pending 0xC.
    step(1, 1, 8'h0A, 0, 0);
    step(1, 1, 8'h0B, 0, 0);
    step(1, 1, 8'h0C, 0, 1);
    check("flush_pre_occ", 32'(bus.occupancy), 32'd2);
    step(1, 0, 8'h00, 0, 0);
    check("flush_occ", 32'(bus.occupancy), 32'd0);
    check("flush_valid", 32'(bus.out_valid), 32'd0);
    check("flush_bubble", 32'(bus.out_data), 32'(BV));
    check("flush_ready", 32'(bus.in_ready), 32'd1);
    // Flush in ONE with accept and drain: both dropped, nothing re-presented.
    step(1, 1, 8'h0A, 0, 0);
    step(1, 1, 8'h0D, 1, 1);
    check("flush1_pre", 32'(bus.out_data), 32'h0A);
    step(1, 0, 8'h00, 1, 0);
    check("flush1_occ", 32'(bus.occupancy), 32'd0);
    step(1, 0, 8'h00, 1, 0);
    check("flush1_still_empty", 32'(bus.out_valid), 32'd0);

    // Reset mid-operation, with flush also high (reset wins, same outcome).
    step(1, 1, 8'h55, 0, 0);
    step(0, 0, 8'h00, 0, 1);
    check("rst_pre", 32'(bus.out_data), 32'h55);
    step(1, 1, 8'h66, 0, 0);
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_occ", 32'(bus.occupancy), 32'd0);
    step(1, 0, 8'h00, 1, 0);
    check("rst_push", 32'(bus.out_data), 32'h66);
    step(1, 0, 8'h00, 1, 0);
    check("rst_drain", 32'(bus.out_data), 32'(BV));

    // Parameter corner: all-ones payload against a non-zero bubble.
    step(1, 1, 8'hFF, 1, 0);
    step(1, 0, 8'h00, 1, 0);
    check("param_ff", 32'(bus.out_data), 32'hFF);
    step(1, 0, 8'h00, 1, 0);
    check("param_bubble", 32'(bus.out_data), 32'h13);

    // Random traffic; scoreboard monitor checks every cycle.
    for (int i = 0; i < 10000; i++) begin
      step(1, 1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 49) == 0), 1'b1);
    end
    step(1, 0, 8'h00, 1, 0);
    step(1, 0, 8'h00, 1, 0);
    step(1, 0, 8'h00, 1, 0);
    @(negedge clock);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
